// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and defaults for the SDRAM port arbiter.
//   state_e    : arbiter FSM states (IDLE, ARM, WAIT)
//   req_id_e   : which requester owns the current SDRAM access
//   AW_DEF     : default SDRAM byte address width
//   STARVE_DEF : default max consecutive loader grants while the CPU waits
//   TIMEOUT_DEF: default WAIT cycles before an access is abandoned
// Optional feature macro used by the arbiter: SDRAM_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int AW_DEF      = 25;
  localparam int STARVE_DEF  = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sdram_port_arb_if.sv
// -----------------------------------------------------------------------------
// sdram_port_arb_if
// Bundles every bus signal of the SDRAM port arbiter: the CPU slot side, the
// ioctl loader side and the SDRAM controller side.
//   slave  : the arbiter's view (takes requests, drives the controller)
//   master : the surrounding system's view (mirror of slave)
// With SDRAM_ARB_STATS_EN defined, cpu_grants / ld_grants are added.
//
// Handshake semantics:
//   cpu_req / ld_req are levels; only a rising edge starts a transaction, and
//   address/data/we are captured on that edge. cpu_wait_n low / ioctl_wait
//   high means "transaction outstanding" and is asserted combinationally in
//   the edge cycle. Toward the controller, sdram_rd / sdram_we are one-cycle
//   strobes issued only while sdram_ready is high; the access is complete on
//   the first later cycle (after the strobe cycle) in which sdram_ready is
//   high, and sdram_dout is valid in that cycle.
// -----------------------------------------------------------------------------
interface sdram_port_arb_if #(
  parameter int AW = 25
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_wait_n;

  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_din;
  logic          ioctl_wait;

  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_din;
  logic [7:0]    sdram_dout;
  logic          sdram_we;
  logic          sdram_rd;
  logic          sdram_ready;

  logic          timeout_err;

`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]   cpu_grants;
  logic [15:0]   ld_grants;
`endif

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  ld_req, ld_addr, ld_din,
    input  sdram_dout, sdram_ready,
`ifdef SDRAM_ARB_STATS_EN
    output cpu_grants, ld_grants,
`endif
    output cpu_dout, cpu_wait_n, ioctl_wait,
    output sdram_addr, sdram_din, sdram_we, sdram_rd,
    output timeout_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output ld_req, ld_addr, ld_din,
    output sdram_dout, sdram_ready,
`ifdef SDRAM_ARB_STATS_EN
    input  cpu_grants, ld_grants,
`endif
    input  cpu_dout, cpu_wait_n, ioctl_wait,
    input  sdram_addr, sdram_din, sdram_we, sdram_rd,
    input  timeout_err
  );

endinterface

// File: rtl/arb_req_latch.sv
// -----------------------------------------------------------------------------
// arb_req_latch
// Per-requester front end: rising-edge detect on the request level, a pending
// flag, and capture of we/address/data on the accepted edge.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   req_i               : request level
//   we_i, addr_i, din_i : transaction fields, captured on the accepted edge
//   clr_i               : retire the pending transaction (completion/abort)
//   active_o            : edge this cycle or transaction pending
//   we_o, addr_o, din_o : fields of the active transaction
// -----------------------------------------------------------------------------
module arb_req_latch
  import sdram_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    din_i,
  input  logic          clr_i,
  output logic          active_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    din_o
);

  logic          req_q;
  logic          pend_q, pend_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          req_edge;
  logic          take;

  assign req_edge = req_i & ~req_q;
  // An edge arriving while a transaction is still pending is dropped.
  assign take     = req_edge & ~pend_q;

  always_comb begin
    pend_d = pend_q;
    we_d   = we_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end else if (take) begin
      pend_d = 1'b1;
    end
    if (take) begin
      we_d   = we_i;
      addr_d = addr_i;
      din_d  = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  // In the edge cycle the fields are not latched yet, so the live inputs are
  // forwarded; this lets the arbiter grant in the same cycle as the edge.
  assign active_o = req_edge | pend_q;
  assign we_o     = pend_q ? we_q   : we_i;
  assign addr_o   = pend_q ? addr_q : addr_i;
  assign din_o    = pend_q ? din_q  : din_i;

endmodule

// File: rtl/sdram_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_port_arb
// Shares one SDRAM controller port between the CPU slot path (byte reads and
// writes) and the ioctl ROM loader (byte writes). Issues one-cycle strobes,
// waits for the controller, returns read data and stalls the requesters.
// Ports:
//   clk, reset_n : single clock, synchronous active-low reset
//   bus          : sdram_port_arb_if.slave (CPU, loader and controller sides,
//                  timeout_err, optional grant counters)
//   dbg_state_o  : current FSM state
// Parameters: AW (address width), STARVE (max consecutive loader grants
// while the CPU waits), TIMEOUT (WAIT cycles before abort).
// Optional feature: define SDRAM_ARB_STATS_EN to add saturating 16-bit
// completed-grant counters cpu_grants / ld_grants on the interface.
// -----------------------------------------------------------------------------
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int STARVE  = STARVE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  sdram_port_arb_if.slave bus,
  output state_e          dbg_state_o
);

  localparam int SW = cnt_w(STARVE);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

  // Requester front ends
  logic          cpu_active, cpu_we_e, cpu_clr;
  logic [AW-1:0] cpu_addr_e;
  logic [7:0]    cpu_din_e;
  logic          ld_active, ld_we_e, ld_clr;
  logic [AW-1:0] ld_addr_e;
  logic [7:0]    ld_din_e;

  arb_req_latch #(.AW(AW)) u_cpu_latch (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (bus.cpu_req),
    .we_i     (bus.cpu_we),
    .addr_i   (bus.cpu_addr),
    .din_i    (bus.cpu_din),
    .clr_i    (cpu_clr),
    .active_o (cpu_active),
    .we_o     (cpu_we_e),
    .addr_o   (cpu_addr_e),
    .din_o    (cpu_din_e)
  );

  // The loader only ever writes.
  arb_req_latch #(.AW(AW)) u_ld_latch (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (bus.ld_req),
    .we_i     (1'b1),
    .addr_i   (bus.ld_addr),
    .din_i    (bus.ld_din),
    .clr_i    (ld_clr),
    .active_o (ld_active),
    .we_o     (ld_we_e),
    .addr_o   (ld_addr_e),
    .din_o    (ld_din_e)
  );

  // Registers
  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  req_id_e       gnt_q, gnt_d;
  logic          gnt_we_q, gnt_we_d;
  logic [AW-1:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]    sdram_din_q, sdram_din_d;
  logic          sdram_we_q, sdram_we_d;
  logic          sdram_rd_q, sdram_rd_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          timeout_err_q, timeout_err_d;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0]   cpu_grants_q, cpu_grants_d;
  logic [15:0]   ld_grants_q, ld_grants_d;
`endif

  // FSM events
  logic issue, pick_ld, done, abort;

  assign issue   = (state_q == IDLE) && bus.sdram_ready && (cpu_active || ld_active);
  // Loader wins unless the CPU is waiting and the loader has used up its run.
  assign pick_ld = ld_active && (!cpu_active || (starve_q < STARVE_MAX));
  assign done    = (state_q == WAIT) && bus.sdram_ready;
  assign abort   = (state_q == WAIT) && !bus.sdram_ready && (wait_cnt_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      wait_cnt_q    <= '0;
      gnt_q         <= REQ_CPU;
      gnt_we_q      <= 1'b0;
      sdram_addr_q  <= '0;
      sdram_din_q   <= '0;
      sdram_we_q    <= 1'b0;
      sdram_rd_q    <= 1'b0;
      cpu_dout_q    <= 8'hFF;
      timeout_err_q <= 1'b0;
`ifdef SDRAM_ARB_STATS_EN
      cpu_grants_q  <= '0;
      ld_grants_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      wait_cnt_q    <= wait_cnt_d;
      gnt_q         <= gnt_d;
      gnt_we_q      <= gnt_we_d;
      sdram_addr_q  <= sdram_addr_d;
      sdram_din_q   <= sdram_din_d;
      sdram_we_q    <= sdram_we_d;
      sdram_rd_q    <= sdram_rd_d;
      cpu_dout_q    <= cpu_dout_d;
      timeout_err_q <= timeout_err_d;
`ifdef SDRAM_ARB_STATS_EN
      cpu_grants_q  <= cpu_grants_d;
      ld_grants_q   <= ld_grants_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = ARM;
      ARM:     state_d = WAIT;
      WAIT:    if (done || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    starve_d      = starve_q;
    wait_cnt_d    = wait_cnt_q;
    gnt_d         = gnt_q;
    gnt_we_d      = gnt_we_q;
    sdram_addr_d  = sdram_addr_q;
    sdram_din_d   = sdram_din_q;
    sdram_we_d    = 1'b0;
    sdram_rd_d    = 1'b0;
    cpu_dout_d    = cpu_dout_q;
    timeout_err_d = timeout_err_q;
    cpu_clr       = 1'b0;
    ld_clr        = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
    cpu_grants_d  = cpu_grants_q;
    ld_grants_d   = ld_grants_q;
`endif

    if (issue) begin
      if (pick_ld) begin
        gnt_d        = REQ_LD;
        gnt_we_d     = ld_we_e;
        sdram_addr_d = ld_addr_e;
        sdram_din_d  = ld_din_e;
        // Only loader grants that bypass a waiting CPU count toward the run.
        if (cpu_active && (starve_q < STARVE_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        gnt_d        = REQ_CPU;
        gnt_we_d     = cpu_we_e;
        sdram_addr_d = cpu_addr_e;
        sdram_din_d  = cpu_din_e;
        starve_d     = '0;
      end
      sdram_we_d = gnt_we_d;
      sdram_rd_d = ~gnt_we_d;
    end

    if (state_q == ARM) begin
      wait_cnt_d = '0;
    end else if ((state_q == WAIT) && !bus.sdram_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (done || abort) begin
      cpu_clr = (gnt_q == REQ_CPU);
      ld_clr  = (gnt_q == REQ_LD);
    end

    if (done && (gnt_q == REQ_CPU) && !gnt_we_q) begin
      cpu_dout_d = bus.sdram_dout;
    end

    if (abort) begin
      timeout_err_d = 1'b1;
      if ((gnt_q == REQ_CPU) && !gnt_we_q) begin
        cpu_dout_d = 8'hFF;
      end
    end

`ifdef SDRAM_ARB_STATS_EN
    // Aborted accesses never reach 'done', so they are not counted.
    if (done) begin
      if (gnt_q == REQ_CPU) begin
        if (cpu_grants_q != 16'hFFFF) cpu_grants_d = cpu_grants_q + 16'd1;
      end else begin
        if (ld_grants_q != 16'hFFFF) ld_grants_d = ld_grants_q + 16'd1;
      end
    end
`endif
  end

  // Stall outputs are combinational from the edge so the CPU stalls in the
  // very cycle it raises its request.
  assign bus.cpu_wait_n  = ~cpu_active;
  assign bus.ioctl_wait  = ld_active;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.sdram_addr  = sdram_addr_q;
  assign bus.sdram_din   = sdram_din_q;
  assign bus.sdram_we    = sdram_we_q;
  assign bus.sdram_rd    = sdram_rd_q;
  assign bus.timeout_err = timeout_err_q;
`ifdef SDRAM_ARB_STATS_EN
  assign bus.cpu_grants  = cpu_grants_q;
  assign bus.ld_grants   = ld_grants_q;
`endif
  assign dbg_state_o     = state_q;

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Shares one SDRAM channel (one index of the sdram_* arrays) between two requesters:
  - the CPU slot path (cartridge ROM/RAM reads and writes);
  - the ioctl ROM loader (download writes).
- Issues single-byte strobes, waits for the controller, and returns read data.
- Generates the CPU wait_n (stalls T80 while pending) and ioctl_wait (loader back-pressure).
- Sits between the slots logic and the SDRAM controller port.

Parameters:
- AW, 25, SDRAM byte address width.
- STARVE, 4, max consecutive loader grants while a CPU request is pending; the next grant then goes to the CPU.
- TIMEOUT, 255, cycles allowed in WAIT before the transaction is aborted.

Ports:
- clk  in  1  system clock; the single clock.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  level; a rising edge starts one CPU transaction.
- cpu_we  in  1  1 = write, 0 = read; sampled on the cpu_req rising edge.
- cpu_addr  in  AW  byte address; sampled with cpu_req.
- cpu_din  in  8  write data; sampled with cpu_req.
- cpu_dout  out  8  registered read data; holds until the next CPU read completes.
- cpu_wait_n  out  1  low while a CPU transaction is pending.
- ld_req  in  1  level; a rising edge starts one loader write.
- ld_addr  in  AW  loader address.
- ld_din  in  8  loader data.
- ioctl_wait  out  1  high while a loader write is pending.
- sdram_addr  out  AW  controller address.
- sdram_din  out  8  controller write data.
- sdram_dout  in  8  controller read data.
- sdram_we  out  1  one-cycle write strobe.
- sdram_rd  out  1  one-cycle read strobe.
- sdram_ready  in  1  controller idle / last access complete.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE; pending flags and edge registers cleared; starve count = 0;
  - cpu_dout = 8'hFF; cpu_wait_n = 1; ioctl_wait = 0;
  - strobes = 0; sdram_addr = 0; sdram_din = 0; timeout_err = 0.
  - A reset mid-transaction abandons it with no completion.
- Request capture:
  - req & ~req_q sets pend and latches addr/data/we.
  - A new edge while pend is set is ignored.
  - cpu_wait_n = ~(cpu_edge | cpu_pend); ioctl_wait = ld_edge | ld_pend. Both are combinational from the edge, so the CPU stalls in the same cycle it asserts the request.
- FSM:
  - IDLE → ARM: when sdram_ready = 1 and any pend is set.
    - Grant goes to the loader if ld_pend and (no cpu_pend or starve < STARVE); otherwise to the CPU.
    - Drive addr/din, pulse sdram_we or sdram_rd for exactly 1 cycle.
    - Loader grant with cpu_pend: starve increments. CPU grant: starve resets to 0.
  - ARM → WAIT: unconditional; sdram_ready is ignored in ARM.
  - WAIT → IDLE: on sdram_ready = 1.
    - Read data is captured into cpu_dout in that cycle.
    - The granted pend clears; cpu_wait_n rises the following cycle.
  - WAIT timeout: the counter increments each WAIT cycle. At TIMEOUT it aborts to IDLE, clears the granted pend, sets cpu_dout = 8'hFF for a CPU read, and sets timeout_err (sticky until reset).
- Minimum latency: request edge → completion = 3 cycles (IDLE, ARM, WAIT with ready already high).
- Edge cases:
  - Simultaneous edges on both requesters: both latch; arbitration as above.
  - sdram_ready low in IDLE: no issue; pends are held.
  - The starve counter saturates at STARVE.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- Defined: adds outputs cpu_grants[15:0] and ld_grants[15:0].
  - Each is a saturating count of completed grants, cleared by reset.
  - Timeouts are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, ARM, WAIT};
  - requester id enum {REQ_CPU, REQ_LD};
  - default localparams for AW, STARVE, TIMEOUT.
- Sub-module arb_req_latch (edge detect + pend flag + address/data/we latch), instantiated once per requester.

Test Plan:
- CPU read, addr 25'h04000, controller returns 8'hA5 with ready high immediately:
  - sdram_rd pulses 1 cycle with sdram_addr = 25'h04000;
  - cpu_dout = 8'hA5; cpu_wait_n is low for exactly 3 cycles.
- Loader write 8'h3C at 25'h10000 while ready is low for 5 cycles after the strobe:
  - sdram_we pulses once; ioctl_wait stays high until ready returns, then drops the next cycle.
- Both requests continuously pending, STARVE = 4:
  - grant order is LD, LD, LD, LD, CPU, LD, …;
  - the CPU transaction completes with the correct data.
- Ready held low after the strobe for 300 cycles, TIMEOUT = 255, CPU read:
  - abort after 255 WAIT cycles; cpu_dout = 8'hFF; timeout_err = 1 and remains set.
- reset_n low during WAIT:
  - next cycle state = IDLE, cpu_wait_n = 1, ioctl_wait = 0, no strobe;
  - a fresh cpu_req edge afterwards is serviced normally.
- With SDRAM_ARB_STATS_EN, 3 CPU reads + 2 loader writes: cpu_grants = 3, ld_grants = 2.
